// File: rtl/qclk_load_arb_pkg.sv
// Shared types and default constants for the qclk load arbiter.
package qclk_load_arb_pkg;
  localparam int DEF_WIDTH        = 32;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_GUARD_CYCLES = 2;
  localparam int GCNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;
endpackage

// File: rtl/qclk_load_arb_rr_arbiter.sv
// Combinational round-robin arbiter: ptr names the highest-priority requester.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_gnt;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot     = NUM_REQ'({req, req} >> ptr);
    rot_gnt = rot & (-rot);
    gnt     = NUM_REQ'(({rot_gnt, rot_gnt} << ptr) >> NUM_REQ);
  end
endmodule

// File: rtl/qclk_load_arb.sv
// Arbitrates qclk counter loads among NUM_REQ requesters with a post-load guard.
// Define QCLK_LOAD_ARB_RELATIVE_EN to load qclk_val + load_val instead of load_val.
module qclk_load_arb
  import qclk_load_arb_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0]         qclk_val,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     qclk_load_enable,
  output logic [WIDTH-1:0]         qclk_in_val,
  output logic                     busy
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [GCNT_W-1:0] GUARD_INIT =
    GCNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  state_t              state_q, state_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                load_en_q, load_en_d;
  logic [WIDTH-1:0]    in_val_q, in_val_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [WIDTH-1:0]    sel_val;
  logic [WIDTH-1:0]    load_sum;
  logic [PTR_W-1:0]    nxt_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    sel_val = '0;
    nxt_ptr = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_val = load_val[i*WIDTH +: WIDTH];
        nxt_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

`ifdef QCLK_LOAD_ARB_RELATIVE_EN
  // Signed offset adjustment; two's-complement add wraps modulo 2^WIDTH.
  assign load_sum = qclk_val + sel_val;
`else
  logic unused_qclk_val;
  assign unused_qclk_val = ^qclk_val;
  assign load_sum        = sel_val;
`endif

  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    load_en_d = 1'b0;
    in_val_d  = in_val_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_LOAD;
          gnt_d     = arb_gnt;
          load_en_d = 1'b1;
          in_val_d  = load_sum;
          ptr_d     = nxt_ptr;
        end
      end
      ST_LOAD: begin
        if (GUARD_CYCLES > 0) begin
          state_d = ST_GUARD;
          gcnt_d  = GUARD_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GUARD: begin
        // req is deliberately ignored until the guard window expires.
        if (gcnt_q == '0) state_d = ST_IDLE;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gcnt_q    <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      load_en_q <= 1'b0;
      in_val_q  <= '0;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      load_en_q <= load_en_d;
      in_val_q  <= in_val_d;
    end
  end

  assign gnt              = gnt_q;
  assign qclk_load_enable = load_en_q;
  assign qclk_in_val      = in_val_q;
  assign busy             = (state_q != ST_IDLE);
endmodule

// File: tb/tb_qclk_load_arb.sv
// Scoreboard bench for qclk_load_arb: transaction-level model predicts loads, monitor compares.
module tb_qclk_load_arb;
  localparam int N = 4;
  localparam int W = 32;
  localparam int G = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req0;
  logic [N*W-1:0] load_val;
  logic [W-1:0]   qclk_val;
  logic [N-1:0]   gnt, gnt0;
  logic           en, en0;
  logic [W-1:0]   inv, inv0;
  logic           busy, busy0;

  qclk_load_arb #(.WIDTH(W), .NUM_REQ(N), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .load_val(load_val), .qclk_val(qclk_val),
    .gnt(gnt), .qclk_load_enable(en), .qclk_in_val(inv), .busy(busy));

  qclk_load_arb #(.WIDTH(W), .NUM_REQ(N), .GUARD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .load_val(load_val), .qclk_val(qclk_val),
    .gnt(gnt0), .qclk_load_enable(en0), .qclk_in_val(inv0), .busy(busy0));

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         w;
    logic [W-1:0] val;
  } exp_t;

  exp_t       sb[$];
  bit         exp_busy[int];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_tot = 0;
  bit         mon_en = 1'b0;
  logic [W-1:0] last_val = '0;
  exp_t       mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a load.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (exp_busy.exists(cyc)) check("busy", 64'(busy), 64'(exp_busy[cyc]));
      if (en || gnt != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_load", 64'({en, gnt}), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("load_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("gnt", 64'(gnt), 64'(1 << mon_e.w));
          check("load_en", 64'(en), 64'd1);
          check("in_val", 64'(inv), 64'(mon_e.val));
          last_val = mon_e.val;
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          check("missed_load_gnt", 64'(gnt), 64'(1 << sb[0].w));
          void'(sb.pop_front());
        end
        check("in_val_hold", 64'(inv), 64'(last_val));
      end
    end
  end

  bit           pend[N];
  logic [W-1:0] val[N];
  int           m_left, m_ptr, m_load_w, m_cur, w;
  bit           m_guard, rst_done, any;
  exp_t         e;
  logic [W-1:0] exp_inv0;

  initial begin
    rst = 1'b1; req = '0; req0 = '0; load_val = '0; qclk_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_en", 64'(en), 64'd0);
    check("reset_inval", 64'(inv), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;

    // Zero-guard instance: two held requesters alternate every second cycle.
    @(posedge clk); #1;
    load_val[0*W +: W] = 32'h111;
    load_val[1*W +: W] = 32'h222;
    req0 = 4'b0011;
    exp_inv0 = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1) exp_inv0 = (k % 4 == 1) ? 32'h111 : 32'h222;
      check("g0_gnt", 64'(gnt0), (k % 2 == 0) ? 64'd0 : ((k % 4 == 1) ? 64'd1 : 64'd2));
      check("g0_en", 64'(en0), 64'(k % 2));
      check("g0_inval", 64'(inv0), 64'(exp_inv0));
    end
    req0 = '0;

    // Main randomized run against the transaction-level model.
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; val[i] = '0; end
    m_left = 0; m_ptr = 0; m_load_w = -1; rst_done = 1'b0;
    mon_en = 1'b1;
    for (int it = 0; it < 440; it++) begin
      @(posedge clk); #1;
      m_cur   = m_load_w;
      m_guard = (m_left > 0) && (m_cur < 0);

      if (it >= 200 && !rst_done && m_cur >= 0) begin
        rst = 1'b1;
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_en", 64'(en), 64'd0);
        check("rst_inval", 64'(inv), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        sb.delete();
        last_val = '0;
        m_left = 0; m_ptr = 0; m_load_w = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        rst_done = 1'b1;
        exp_busy[cyc] = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; val[i] = $urandom; end
      end else begin
        if (m_cur >= 0) pend[m_cur] = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!pend[i]) begin
            if ((it == 0 && i == 0) ||
                (it >= 10 && it < 40) ||
                (it >= 40 && it < 400 && $urandom_range(0, 2) == 0)) begin
              pend[i] = 1'b1;
              val[i]  = (it == 0) ? 32'h100 : $urandom;
`ifdef QCLK_LOAD_ARB_RELATIVE_EN
              if (it == 0) val[i] = 32'h20;
`endif
            end
          end else if (m_guard && it >= 40 && $urandom_range(0, 3) == 0) begin
            pend[i] = 1'b0;
          end
        end
      end

      for (int i = 0; i < N; i++) begin
        req[i] = pend[i];
        load_val[i*W +: W] = pend[i] ? val[i] : W'($urandom);
      end
      qclk_val = (it < 10) ? 32'hFFFF_FFF0 : W'($urandom);

      // Predict the next edge from the protocol rules.
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= pend[i];
      if (m_left == 0 && any) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        e.cyc = cyc + 1;
        e.w   = w;
`ifdef QCLK_LOAD_ARB_RELATIVE_EN
        e.val = qclk_val + val[w];
`else
        e.val = val[w];
`endif
        sb.push_back(e);
        m_ptr    = (w + 1) % N;
        m_left   = 1 + G;
        m_load_w = w;
      end else begin
        if (m_left > 0) m_left--;
        m_load_w = -1;
      end
      exp_busy[cyc + 1] = (m_left > 0);
    end

    repeat (3) @(negedge clk);
    check("reset_in_load_exercised", 64'(rst_done), 64'd1);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
